// File: rtl/sub_arbiter.sv
// Four requesters share one subtractor: grant in IDLE, compute in EXEC, result held in HOLD.
// Valid follows Grant by 2 cycles; result held stable until Rdy, new grants blocked meanwhile.

module sub #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [DATAWIDTH-1:0] diff_o
);
  assign diff_o = a_i - b_i;
endmodule

module sub_arbiter #(
  parameter int DATAWIDTH = 64
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [3:0]               Req,
  input  logic [4*DATAWIDTH-1:0]   A_in,
  input  logic [4*DATAWIDTH-1:0]   B_in,
  input  logic                     Rdy,
  output logic [3:0]               Grant,
  output logic [DATAWIDTH-1:0]     DIFF,
  output logic                     Borrow,
  output logic [1:0]               Id,
  output logic                     Valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [DATAWIDTH-1:0]  a_q, a_d;
  logic [DATAWIDTH-1:0]  b_q, b_d;
  logic [DATAWIDTH-1:0]  diff_q, diff_d;
  logic                  borrow_q, borrow_d;
  logic [1:0]            id_q, id_d;
  logic                  valid_q, valid_d;

  logic [DATAWIDTH-1:0]  a_lane [4];
  logic [DATAWIDTH-1:0]  b_lane [4];
  logic [DATAWIDTH-1:0]  sub_diff;
  logic                  win_vld;
  logic [1:0]            win_idx;
  logic [3:0]            grant_c;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign a_lane[g] = A_in[g*DATAWIDTH +: DATAWIDTH];
    assign b_lane[g] = B_in[g*DATAWIDTH +: DATAWIDTH];
  end

  sub #(
    .DATAWIDTH (DATAWIDTH)
  ) u_sub (
    .a_i    (a_q),
    .b_i    (b_q),
    .diff_o (sub_diff)
  );

  // Round-robin search starting at ptr_q; 2-bit addition wraps modulo 4.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!win_vld && Req[ptr_q + 2'(i)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    id_d     = id_q;
    valid_d  = valid_q;
    grant_c  = 4'b0000;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_c[win_idx] = 1'b1;
          a_d              = a_lane[win_idx];
          b_d              = b_lane[win_idx];
          id_d             = win_idx;
          state_d          = EXEC;
        end
      end
      EXEC: begin
        diff_d   = sub_diff;
        borrow_d = (a_q < b_q);
        valid_d  = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (Rdy) begin
          valid_d = 1'b0;
          ptr_d   = id_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      id_q     <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
    end
  end

  // Grant is the IDLE-cycle acceptance strobe; the following edge latches the winner.
  assign Grant  = Rst ? grant_c : 4'b0000;
  assign DIFF   = diff_q;
  assign Borrow = borrow_q;
  assign Id     = id_q;
  assign Valid  = valid_q;

endmodule
